// File: rtl/sprite_pixel_fifo.sv
// Sprite pixel FIFO for the PPU mode-3 pipeline.
// Whole sprite rows are flipped, left-clipped and merged into a circular
// queue of {colour, attr} slots. An opaque pixel already queued beats a new
// one at the same slot. The pixel mixer pops one pixel per request, and an
// empty queue returns a transparent pixel.
module sprite_pixel_fifo #(
  parameter  int PIXEL_W    = 2,
  parameter  int ATTR_W     = 2,
  parameter  int ROW_PIXELS = 8,
  parameter  int DEPTH      = 8,
  localparam int OCC_W      = $clog2(DEPTH + 1),
  localparam int DSC_W      = $clog2(ROW_PIXELS + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         clear_in,
  input  logic                         push_in,
  input  logic [ROW_PIXELS*PIXEL_W-1:0] row_color_in,
  input  logic [ATTR_W-1:0]            row_attr_in,
  input  logic                         xflip_in,
  input  logic [DSC_W-1:0]             discard_in,
  input  logic                         pop_in,
  output logic [PIXEL_W-1:0]           pixel_out,
  output logic [ATTR_W-1:0]            attr_out,
  output logic                         pixel_valid_out,
  output logic [OCC_W-1:0]             occupancy_out,
  output logic                         empty_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  genvar gi;

  // A row longer than the queue could never be merged in one go.
  if (DEPTH < ROW_PIXELS) begin : g_bad_depth
    $error("sprite_pixel_fifo: DEPTH must be >= ROW_PIXELS");
  end

  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0]   occ_reg, occ_next;
  logic [PIXEL_W-1:0] pixel_reg;
  logic [ATTR_W-1:0]  attr_reg;
  logic               valid_reg;

  // Row pixels after the optional X flip, leftmost first.
  logic [PIXEL_W-1:0] row_pix [ROW_PIXELS];
  // Read-only views of every slot, used to fetch the head on a pop.
  logic [PIXEL_W-1:0] slot_color [DEPTH];
  logic [ATTR_W-1:0]  slot_attr  [DEPTH];

  // Control terms shared by every slot, all taken after any same-cycle pop.
  logic pop_live;
  logic push_live;
  int   occ_pop_i;
  int   ptr_pop_i;
  int   dsc_i;
  int   row_n_i;

  for (gi = 0; gi < ROW_PIXELS; gi++) begin : g_row
    assign row_pix[gi] = xflip_in ? row_color_in[(ROW_PIXELS-1-gi)*PIXEL_W +: PIXEL_W]
                                  : row_color_in[gi*PIXEL_W +: PIXEL_W];
  end

  // Resolve clear > pop > push into post-pop head, occupancy and row length.
  always_comb begin
    pop_live  = pop_in && !clear_in && (occ_reg != '0);
    occ_pop_i = int'(occ_reg) - (pop_live ? 1 : 0);
    ptr_pop_i = int'(rd_ptr_reg);
    if (pop_live) begin
      ptr_pop_i = (int'(rd_ptr_reg) == DEPTH - 1) ? 0 : int'(rd_ptr_reg) + 1;
    end
    dsc_i     = int'(discard_in);
    push_live = push_in && !clear_in && (dsc_i < ROW_PIXELS);
    row_n_i   = push_live ? (ROW_PIXELS - dsc_i) : 0;
    if (clear_in) begin
      occ_next    = '0;
      rd_ptr_next = rd_ptr_reg;
    end else begin
      occ_next    = OCC_W'((row_n_i > occ_pop_i) ? row_n_i : occ_pop_i);
      rd_ptr_next = PTR_W'(ptr_pop_i);
    end
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PIXEL_W-1:0] color_reg, color_next;
    logic [ATTR_W-1:0]  attr_slot_reg, attr_slot_next;
    logic [PIXEL_W-1:0] src_color;
    int                 k;

    assign slot_color[gi] = color_reg;
    assign slot_attr[gi]  = attr_slot_reg;

    // Slot update: flush, vacate on pop, then merge the incoming row pixel.
    always_comb begin
      k = (gi >= ptr_pop_i) ? (gi - ptr_pop_i) : (gi + DEPTH - ptr_pop_i);
      src_color = '0;
      for (int j = 0; j < ROW_PIXELS; j++) begin
        if (j == k + dsc_i) src_color = row_pix[j];
      end
      color_next     = color_reg;
      attr_slot_next = attr_slot_reg;
      if (clear_in) begin
        color_next = '0;
      end else begin
        // The popped slot becomes free space, which must read transparent.
        if (pop_live && (int'(rd_ptr_reg) == gi)) color_next = '0;
        // Free space takes anything; queued slots only yield if transparent.
        if ((k < row_n_i) && ((k >= occ_pop_i) || (color_next == '0))) begin
          color_next     = src_color;
          attr_slot_next = row_attr_in;
        end
      end
    end

    // Slot storage register.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        color_reg     <= '0;
        attr_slot_reg <= '0;
      end else begin
        color_reg     <= color_next;
        attr_slot_reg <= attr_slot_next;
      end
    end
  end

  // Queue pointer and occupancy register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Registered pop result; colour and attr hold when no pop is requested.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_reg <= '0;
      attr_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (pop_in && !clear_in) begin
      valid_reg <= 1'b1;
      if (occ_reg != '0) begin
        pixel_reg <= slot_color[rd_ptr_reg];
        attr_reg  <= slot_attr[rd_ptr_reg];
      end else begin
        pixel_reg <= '0;
        attr_reg  <= '0;
      end
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign pixel_out       = pixel_reg;
  assign attr_out        = attr_reg;
  assign pixel_valid_out = valid_reg;
  assign occupancy_out   = occ_reg;
  assign empty_out       = (occ_reg == '0);

endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Directed bench for sprite_pixel_fifo with hand-computed expectations.
module tb_sprite_pixel_fifo;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        clear_in;
  logic        push_in;
  logic [15:0] row_color_in;
  logic [1:0]  row_attr_in;
  logic        xflip_in;
  logic [3:0]  discard_in;
  logic        pop_in;
  logic [1:0]  pixel_out;
  logic [1:0]  attr_out;
  logic        pixel_valid_out;
  logic [3:0]  occupancy_out;
  logic        empty_out;

  int checks = 0;
  int errors = 0;

  sprite_pixel_fifo #(
    .PIXEL_W(2), .ATTR_W(2), .ROW_PIXELS(8), .DEPTH(8)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in), .push_in(push_in),
    .row_color_in(row_color_in), .row_attr_in(row_attr_in), .xflip_in(xflip_in),
    .discard_in(discard_in), .pop_in(pop_in), .pixel_out(pixel_out),
    .attr_out(attr_out), .pixel_valid_out(pixel_valid_out),
    .occupancy_out(occupancy_out), .empty_out(empty_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] row, input logic [1:0] attr,
                      input logic flip, input logic [3:0] d);
    row_color_in = row; row_attr_in = attr; xflip_in = flip; discard_in = d;
    push_in = 1'b1;
    step();
    push_in = 1'b0;
    $display("push row=%h attr=%0d flip=%0d d=%0d -> occ=%0d", row, attr, flip, d, occupancy_out);
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] pix, input logic [1:0] attr);
    pop_in = 1'b1;
    step();
    pop_in = 1'b0;
    $display("pop %s -> valid=%0d pixel=%0d attr=%0d occ=%0d", tag, pixel_valid_out,
             pixel_out, attr_out, occupancy_out);
    check({tag, "_valid"}, 32'(pixel_valid_out), 32'd1);
    check({tag, "_pixel"}, 32'(pixel_out), 32'(pix));
    check({tag, "_attr"},  32'(attr_out),  32'(attr));
  endtask

  initial begin
    rst_in = 1'b1; clear_in = 1'b0; push_in = 1'b0; pop_in = 1'b0;
    row_color_in = '0; row_attr_in = '0; xflip_in = 1'b0; discard_in = '0;
    step(); step();
    check("rst_occ",   32'(occupancy_out),   32'd0);
    check("rst_empty", 32'(empty_out),       32'd1);
    check("rst_valid", 32'(pixel_valid_out), 32'd0);
    check("rst_pixel", 32'(pixel_out),       32'd0);
    rst_in = 1'b0;

    // Pops on an empty queue return transparent and never underflow.
    pop_chk("empty_pop0", 2'd0, 2'd0);
    pop_chk("empty_pop1", 2'd0, 2'd0);
    check("empty_occ", 32'(occupancy_out), 32'd0);

    // Row 0,1,2,3,3,2,1,0 into an empty queue, no flip, no discard.
    push(16'h1BE4, 2'b10, 1'b0, 4'd0);
    check("row_occ", 32'(occupancy_out), 32'd8);
    pop_chk("row_p0", 2'd0, 2'b10);
    pop_chk("row_p1", 2'd1, 2'b10);
    pop_chk("row_p2", 2'd2, 2'b10);
    pop_chk("row_p3", 2'd3, 2'b10);
    pop_chk("row_p4", 2'd3, 2'b10);
    pop_chk("row_p5", 2'd2, 2'b10);
    pop_chk("row_p6", 2'd1, 2'b10);
    pop_chk("row_p7", 2'd0, 2'b10);
    check("row_empty", 32'(empty_out), 32'd1);

    // Same palindromic row flipped, 3 dropped: 3,3,2,1,0.
    push(16'h1BE4, 2'b10, 1'b1, 4'd3);
    check("flip_occ", 32'(occupancy_out), 32'd5);
    pop_chk("flip_p0", 2'd3, 2'b10);
    pop_chk("flip_p1", 2'd3, 2'b10);
    pop_chk("flip_p2", 2'd2, 2'b10);
    pop_chk("flip_p3", 2'd1, 2'b10);
    pop_chk("flip_p4", 2'd0, 2'b10);
    pop_chk("flip_p5", 2'd0, 2'b00);

    // Asymmetric row 1,2,3,0,0,0,0,0 flipped, 5 dropped: 3,2,1.
    push(16'h0039, 2'b01, 1'b1, 4'd5);
    check("asym_occ", 32'(occupancy_out), 32'd3);
    pop_chk("asym_p0", 2'd3, 2'b01);
    pop_chk("asym_p1", 2'd2, 2'b01);
    pop_chk("asym_p2", 2'd1, 2'b01);

    // Discard of a whole row changes nothing.
    push(16'hFFFF, 2'b11, 1'b0, 4'd8);
    check("dsc8_occ", 32'(occupancy_out), 32'd0);

    // Merge: queued 1,0,2,0,... attr 1; pushed all-3 attr 2.
    push(16'h0021, 2'b01, 1'b0, 4'd0);
    push(16'hFFFF, 2'b10, 1'b0, 4'd0);
    check("merge_occ", 32'(occupancy_out), 32'd8);
    pop_chk("merge_p0", 2'd1, 2'b01);
    pop_chk("merge_p1", 2'd3, 2'b10);
    pop_chk("merge_p2", 2'd2, 2'b01);
    pop_chk("merge_p3", 2'd3, 2'b10);
    pop_chk("merge_p4", 2'd3, 2'b10);
    pop_chk("merge_p5", 2'd3, 2'b10);
    pop_chk("merge_p6", 2'd3, 2'b10);
    pop_chk("merge_p7", 2'd3, 2'b10);
    step();
    check("hold_valid", 32'(pixel_valid_out), 32'd0);
    check("hold_pixel", 32'(pixel_out),       32'd3);
    check("hold_attr",  32'(attr_out),        32'd2);

    // Occupancy 3 (3,2,1 attr 1), then pop + push all-1 attr 2 in one cycle.
    push(16'h0039, 2'b01, 1'b1, 4'd5);
    check("pp_occ3", 32'(occupancy_out), 32'd3);
    row_color_in = 16'h5555; row_attr_in = 2'b10; xflip_in = 1'b0; discard_in = 4'd0;
    push_in = 1'b1;
    pop_chk("pp_head", 2'd3, 2'b01);
    push_in = 1'b0;
    check("pp_occ8", 32'(occupancy_out), 32'd8);
    pop_chk("pp_p0", 2'd2, 2'b01);
    pop_chk("pp_p1", 2'd1, 2'b01);
    for (int i = 0; i < 6; i++) pop_chk($sformatf("pp_p%0d", i + 2), 2'd1, 2'b10);
    check("pp_empty", 32'(empty_out), 32'd1);

    // Clear wins over same-cycle pop and push.
    push(16'h1BE4, 2'b00, 1'b0, 4'd0);
    clear_in = 1'b1; push_in = 1'b1; pop_in = 1'b1; row_color_in = 16'hFFFF;
    step();
    clear_in = 1'b0; push_in = 1'b0; pop_in = 1'b0;
    $display("clear -> occ=%0d valid=%0d empty=%0d", occupancy_out, pixel_valid_out, empty_out);
    check("clr_occ",   32'(occupancy_out),   32'd0);
    check("clr_valid", 32'(pixel_valid_out), 32'd0);
    check("clr_empty", 32'(empty_out),       32'd1);
    pop_chk("clr_pop", 2'd0, 2'd0);

    // Asynchronous reset pulse mid-row, observed before the next clock edge.
    push(16'h1BE4, 2'b11, 1'b0, 4'd0);
    pop_chk("ar_pop", 2'd0, 2'b11);
    pop_in = 1'b1;
    step();
    #2 rst_in = 1'b1;
    #1;
    $display("async reset -> occ=%0d valid=%0d pixel=%0d empty=%0d", occupancy_out,
             pixel_valid_out, pixel_out, empty_out);
    check("ar_occ",   32'(occupancy_out),   32'd0);
    check("ar_valid", 32'(pixel_valid_out), 32'd0);
    check("ar_pixel", 32'(pixel_out),       32'd0);
    check("ar_attr",  32'(attr_out),        32'd0);
    check("ar_empty", 32'(empty_out),       32'd1);
    pop_in = 1'b0;
    step();
    rst_in = 1'b0;
    pop_chk("ar_after", 2'd0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
